// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types.
// FSM state encoding and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle.
// Two requester ports, shared read data, RAM side.
interface mem_arbiter_if #(
  parameter int DEPTH = 9,
  parameter int WIDTH = 32,
  parameter int AW    = 32
);

  logic             req0;
  logic             we0;
  logic [AW-1:0]    addr0;
  logic [WIDTH-1:0] wdata0;
  logic             ack0;
  logic             err0;

  logic             req1;
  logic             we1;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] wdata1;
  logic             ack1;
  logic             err1;

  logic [WIDTH-1:0] rdata;

  logic             ram_wr_en;
  logic [DEPTH-1:0] ram_r_addr;
  logic [DEPTH-1:0] ram_w_addr;
  logic [WIDTH-1:0] ram_w_data;
  logic [WIDTH-1:0] ram_r_data;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_r_data,
    input  ack0, err0, ack1, err1,
    input  rdata,
    input  ram_wr_en, ram_r_addr,
    input  ram_w_addr, ram_w_data
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_r_data,
    output ack0, err0, ack1, err1,
    output rdata,
    output ram_wr_en, ram_r_addr,
    output ram_w_addr, ram_w_data
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant.
// Pure combinational; history register lives in the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       valid
);

  // On a tie, grant the port that was not served last
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req[0] && !req[1]): gnt = 2'b01;
      (req[1] && !req[0]): gnt = 2'b10;
      (req[0] && req[1]):  gnt = last ? 2'b01 : 2'b10;
      default:             gnt = 2'b00;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port RAM.
// Fixed IDLE -> ACCESS -> RESP sequence per transaction.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int WIDTH = 32,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  state_t           state;
  logic             owner;
  logic             last;
  logic             lat_we;
  logic [AW-1:0]    lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic [WIDTH-1:0] rdata_q;
  logic [1:0]       ack_q;
  logic [1:0]       err_q;

  logic [1:0]       gnt;
  logic             gnt_vld;
  logic             sel;
  logic             in_range;

  rr_arb2 u_rr (
    .req   ({bus.req1, bus.req0}),
    .last  (last),
    .gnt   (gnt),
    .valid (gnt_vld)
  );

  assign sel      = gnt[1] ? P1 : P0;
  assign in_range = (lat_addr >> DEPTH) == '0;

  assign bus.ram_r_addr = lat_addr[DEPTH-1:0];
  assign bus.ram_w_addr = lat_addr[DEPTH-1:0];
  assign bus.ram_w_data = lat_wdata;
  assign bus.ram_wr_en  = (state == ACCESS) && lat_we && in_range;

  assign bus.ack0  = ack_q[0];
  assign bus.ack1  = ack_q[1];
  assign bus.err0  = err_q[0];
  assign bus.err1  = err_q[1];
  assign bus.rdata = rdata_q;

  // Sequencer: latch winner, access RAM, pulse ack for the owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= P0;
      last      <= P1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          ack_q <= 2'b00;
          err_q <= 2'b00;
          if (gnt_vld) begin
            owner     <= sel;
            lat_we    <= sel ? bus.we1 : bus.we0;
            lat_addr  <= sel ? bus.addr1 : bus.addr0;
            lat_wdata <= sel ? bus.wdata1 : bus.wdata0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= (!lat_we && in_range) ? bus.ram_r_data : '0;
          ack_q   <= (owner == P1) ? 2'b10 : 2'b01;
          err_q   <= in_range ? 2'b00 :
                     ((owner == P1) ? 2'b10 : 2'b01);
          state   <= RESP;
        end
        RESP: begin
          ack_q <= 2'b00;
          err_q <= 2'b00;
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Scoreboard of expected acks plus a behavioural RAM.
module tb_mem_arbiter;

  localparam int DEPTH = 9;
  localparam int WIDTH = 32;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ram_init = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) bus ();

  mem_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem    [512];
  logic [31:0] shadow [512];

  function automatic logic [31:0] seed(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0000_0107);
  endfunction

  assign bus.ram_r_data = mem[bus.ram_r_addr];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= seed(i);
    end else if (bus.ram_wr_en) begin
      mem[bus.ram_w_addr] <= bus.ram_w_data;
    end
  end

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  typedef struct {
    logic        p;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  exp_t m;

  always @(negedge clk) begin
    if (bus.ram_wr_en) wr_cnt++;
    if (rst_n && (bus.ack0 || bus.ack1)) begin
      chk("ack_both", {63'd0, bus.ack0 & bus.ack1}, 64'd0);
      if (sb.size() == 0) begin
        chk("ack_unexpected", 64'd1, 64'd0);
      end else begin
        m = sb.pop_front();
        chk("ack_port", {63'd0, bus.ack1}, {63'd0, m.p});
        chk("ack_err", {63'd0, bus.ack1 ? bus.err1 : bus.err0},
            {63'd0, m.err});
        chk("rdata", {32'd0, bus.rdata}, {32'd0, m.data});
      end
    end
  end

  function automatic exp_t mk_exp(input logic p, input logic we,
                                  input logic [31:0] a);
    exp_t e;
    e.p    = p;
    e.err  = (a >> DEPTH) != 0;
    e.data = (we || e.err) ? 32'd0 : shadow[a[DEPTH-1:0]];
    return e;
  endfunction

  task automatic txn(input logic p, input logic we,
                     input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   lat;
    e = mk_exp(p, we, a);
    if (we && !e.err) shadow[a[DEPTH-1:0]] = d;
    sb.push_back(e);
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(p ? bus.ack1 : bus.ack0) && lat < 20);
    chk($sformatf("latency_p%0d", p), 64'(lat), 64'd3);
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int a1;
    int w0;
    int q[$];
    int n0;

    bus.req0 = 1'b0; bus.we0 = 1'b0;
    bus.addr0 = '0;  bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    bus.addr1 = '0;  bus.wdata1 = '0;
    for (int i = 0; i < 512; i++) shadow[i] = seed(i);

    @(posedge clk);
    @(posedge clk);
    #1;
    ram_init = 1'b0;
    chk("rst_ack0", {63'd0, bus.ack0}, 64'd0);
    chk("rst_ack1", {63'd0, bus.ack1}, 64'd0);
    chk("rst_err0", {63'd0, bus.err0}, 64'd0);
    chk("rst_err1", {63'd0, bus.err1}, 64'd0);
    chk("rst_rdata", {32'd0, bus.rdata}, 64'd0);
    chk("rst_wr_en", {63'd0, bus.ram_wr_en}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    w0 = wr_cnt;
    txn(1'b0, 1'b1, 32'h005, 32'hDEAD_BEEF);
    chk("wr_en_once", 64'(wr_cnt - w0), 64'd1);
    txn(1'b0, 1'b0, 32'h005, 32'h0);

    rst_pulse();
    sb.push_back(mk_exp(1'b0, 1'b0, 32'h005));
    sb.push_back(mk_exp(1'b1, 1'b0, 32'h007));
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h005;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h007;
    a0 = 0;
    a1 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.ack0) a0 = k;
      if (bus.ack1) a1 = k;
      @(posedge clk);
      #1;
      if (a0 == k) bus.req0 = 1'b0;
      if (a1 == k) bus.req1 = 1'b0;
    end
    chk("tie_ack0_cycle", 64'(a0), 64'd3);
    chk("tie_ack1_cycle", 64'(a1), 64'd6);

    for (int j = 0; j < 2; j++) begin
      sb.push_back(mk_exp(1'b0, 1'b0, 32'h020));
      sb.push_back(mk_exp(1'b1, 1'b0, 32'h021));
    end
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h020;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h021;
    q = {};
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.ack0) q.push_back(0);
      if (bus.ack1) q.push_back(1);
      @(posedge clk);
      #1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk("rr_count", 64'(q.size()), 64'd4);
    n0 = 0;
    for (int j = 0; j < q.size(); j++) begin
      chk($sformatf("rr_order_%0d", j), 64'(q[j]), 64'(j % 2));
      if (q[j] == 0) n0++;
    end
    chk("rr_port0_acks", 64'(n0), 64'd2);

    w0 = wr_cnt;
    txn(1'b1, 1'b1, 32'h200, 32'h1234_5678);
    chk("oor_no_write", 64'(wr_cnt - w0), 64'd0);
    txn(1'b0, 1'b0, 32'h000, 32'h0);
    txn(1'b1, 1'b0, 32'h8000_0005, 32'h0);

    sb.push_back(mk_exp(1'b0, 1'b0, 32'h005));
    sb.push_back(mk_exp(1'b0, 1'b0, 32'h005));
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h005;
    q = {};
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.ack0) q.push_back(k);
      @(posedge clk);
      #1;
      if (k == 5) bus.req0 = 1'b0;
    end
    chk("held_count", 64'(q.size()), 64'd2);
    if (q.size() == 2) begin
      chk("held_first", 64'(q[0]), 64'd3);
      chk("held_second", 64'(q[1]), 64'd6);
    end

    bus.req0 = 1'b1; bus.we0 = 1'b1;
    bus.addr0 = 32'h010; bus.wdata0 = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    chk("mid_wr_en_high", {63'd0, bus.ram_wr_en}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_wr_en_drop", {63'd0, bus.ram_wr_en}, 64'd0);
    @(posedge clk);
    #1;
    chk("mid_ram_kept", {32'd0, mem[16]}, {32'd0, shadow[16]});
    chk("mid_rdata_rst", {32'd0, bus.rdata}, 64'd0);
    chk("mid_no_ack", {62'd0, bus.ack1, bus.ack0}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    txn(1'b0, 1'b0, 32'h010, 32'h0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port `ram` block (async read, sync write, 2^DEPTH x WIDTH).
- Port 0 is the CPU datapath memory interface (MAR/MDR side); port 1 is the I/O or debug loader.
- Each transaction uses a req/ack handshake and a fixed 3-cycle sequence.
- Ties are resolved round-robin; addresses outside the RAM are flagged as errors and never reach the RAM.

Parameters:
- DEPTH, 9, RAM address width; RAM holds 2^DEPTH words.
- WIDTH, 32, data word width.
- AW, 32, requester address width; must be >= DEPTH.

Ports:
- clk  in  1  rising-edge system clock.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held with we0/addr0/wdata0 until ack0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  AW  port 0 word address.
- wdata0  in  WIDTH  port 0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- err0  out  1  valid with ack0; address was out of range.
- req1, we1, addr1, wdata1, ack1, err1: same as port 0, for port 1.
- rdata  out  WIDTH  read data, shared by both ports; valid only while ack0 or ack1 is high.
- ram_wr_en  out  1  drives ram wr_en.
- ram_r_addr  out  DEPTH  drives ram r_addr.
- ram_w_addr  out  DEPTH  drives ram w_addr.
- ram_w_data  out  WIDTH  drives ram w_data.
- ram_r_data  in  WIDTH  from ram r_data (combinational).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ack0/1=0; err0/1=0; rdata=0; latched regs=0; last=1, so port 0 wins the first tie.
  - ram_wr_en=0 immediately.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. No other transitions.
- IDLE:
  - If exactly one req is high, select that port.
  - If both are high, select port ~last.
  - On the clock edge, latch owner, we, addr and wdata of the selected port, then go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - ram_r_addr and ram_w_addr = lat_addr[DEPTH-1:0]; ram_w_data = lat_wdata.
  - ram_wr_en = lat_we & in_range. It is combinational from state and is only ever high in ACCESS.
  - in_range = (lat_addr[AW-1:DEPTH] == 0).
  - On the clock edge:
    - Reads capture rdata <= in_range ? ram_r_data : 0.
    - Writes capture rdata <= 0.
    - err_owner <= ~in_range.
  - Next state RESP.
- RESP:
  - ack[owner]=1 for exactly one cycle; err[owner] is valid in the same cycle.
  - On the clock edge, last <= owner; next state IDLE.
- Latency: request to ack is 3 cycles (IDLE, ACCESS, RESP). Maximum throughput is 1 access per 3 cycles.
- Requester contract:
  - After seeing ack, the requester drops req or presents a new transaction by the next edge.
  - The arbiter samples req only in IDLE, so a request held through RESP is never double-served.
- Fairness: a port that is continuously requesting waits at most one other transaction, i.e. at most 6 cycles to ack.
- Inputs are ignored outside IDLE. Changing req or addr in ACCESS or RESP has no effect on the current transaction.
- Out-of-range write: no RAM write occurs; ack plus err.
- Out-of-range read: rdata=0; ack plus err.
- ram_wr_en is never asserted for an out-of-range address.
- Outside ACCESS, ram_r_addr/ram_w_addr/ram_w_data hold the latched values and ram_wr_en=0.
- Reset asserted in ACCESS: the write is aborted (wr_en drops asynchronously) and no ack is issued.
- Reset asserted in RESP: the ack is suppressed.
- ack0 and ack1 are never high together.

Decomposition:
- Package mem_arb_pkg contains:
  - State enum {IDLE, ACCESS, RESP}, 2-bit encoding.
  - Port index constants P0=0, P1=1.
- One sub-module, rr_arb2: inputs req[1:0] and last; outputs a one-hot grant and valid. It is combinational and holds no state; the last register lives in mem_arbiter.

Test Plan:
- Write then read, single port:
  - Stimulus: port 0 writes 0xDEADBEEF to addr 0x005, then reads addr 0x005.
  - Response: ram_wr_en high for exactly one cycle; each ack0 arrives 3 cycles after its req; read returns rdata=0xDEADBEEF, err0=0.
- Simultaneous requests after reset:
  - Stimulus: req0 and req1 raised in the same cycle, both reads.
  - Response: port 0 is served first, ack0 at cycle 3, ack1 at cycle 6; never both acks in one cycle.
- Sustained contention:
  - Stimulus: both ports request continuously for 12 cycles.
  - Response: acks alternate 0,1,0,1; each port receives 2 acks.
- Out-of-range write:
  - Stimulus: port 1 writes to addr 0x200 (DEPTH=9).
  - Response: ack1 with err1=1; ram_wr_en stays 0; a subsequent read of addr 0x000 returns its old value.
- Reset mid-write:
  - Stimulus: rst_n pulled low during ACCESS of a write to addr 0x010.
  - Response: ram_wr_en falls immediately; RAM[0x010] is unchanged; no ack; after reset, state is IDLE and rdata=0.
- Held request through RESP:
  - Stimulus: port 0 holds req0 high for two cycles after ack0 with the same address.
  - Response: the transaction is served twice (a second ack at +3 cycles) and never more than once per 3 cycles.
